// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, default latencies
// and FSM state encoding.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer with HI/LO ownership and D-stage stall generation.
// Define MDU_MADD_EN to accept MADD/MSUB (accumulate into HI/LO with MUL_CYCLES latency).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             wr_hilo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             d_md_use,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);
  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;
  logic             nowr_q, nowr_d;

  logic [W2-1:0]    prod_s, prod_u;
  logic [WIDTH-1:0] b_safe, quo_s, rem_s, quo_u, rem_u;
  logic             b_zero;

  // Divisor is forced to 1 on b==0 so the divider never sees zero; the result is
  // discarded at commit anyway.
  always_comb begin
    b_zero = (b == '0);
    b_safe = b_zero ? WIDTH'(1) : b;
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    quo_s  = WIDTH'($signed(a) / $signed(b_safe));
    rem_s  = WIDTH'($signed(a) % $signed(b_safe));
    quo_u  = a / b_safe;
    rem_u  = a % b_safe;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    nowr_d  = nowr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          nowr_d  = 1'b0;
          cnt_d   = CW'(MUL_CYCLES);
          case (op)
            OP_MULT:  {phi_d, plo_d} = prod_s;
            OP_MULTU: {phi_d, plo_d} = prod_u;
            OP_DIV: begin
              phi_d  = rem_s;
              plo_d  = quo_s;
              nowr_d = b_zero;
              cnt_d  = CW'(DIV_CYCLES);
            end
            OP_DIVU: begin
              phi_d  = rem_u;
              plo_d  = quo_u;
              nowr_d = b_zero;
              cnt_d  = CW'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {phi_d, plo_d} = {hi_q, lo_q} + prod_s;
            OP_MSUB:  {phi_d, plo_d} = {hi_q, lo_q} - prod_s;
`endif
            // Codes that are not sequenced ops leave the MDU idle.
            default: begin
              state_d = IDLE;
              cnt_d   = cnt_q;
              nowr_d  = nowr_q;
            end
          endcase
        end else if (wr_hilo) begin
          if (op == OP_MTHI)      hi_d = a;
          else if (op == OP_MTLO) lo_d = a;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (!nowr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      nowr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      nowr_q  <= nowr_d;
    end
  end

  assign busy  = (state_q == BUSY);
  assign stall = d_md_use & (busy | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
